// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller: owns every datapath strobe across
// fetch/decode/execute/memory/write-back and counts retired instructions.
module multicycle_control (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [5:0]  Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        IllegalOp,
    output logic [3:0]  StateOut,
    output logic [31:0] InstrCount
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_ILLEGAL = 4'd15
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_count;
    logic        retire;

    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        i_or_d;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_source;
    logic        illegal;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = MemReady;
                pc_write  = MemReady;
                if (MemReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (Opcode)
                    OP_RTYPE:      state_next = S_EXEC;
                    OP_LW, OP_SW:  state_next = S_MEMADR;
                    OP_BEQ:        state_next = S_BRANCH;
                    OP_ADDI:       state_next = S_ADDIEX;
                    OP_J:          state_next = S_JUMP;
                    default:       state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (MemReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                // held for every wait cycle; memory commits only on MemReady
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (MemReady) state_next = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = S_RWB;
            end
            S_RWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_source  = 2'b01;
                pc_write   = Zero;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            default: begin
                // ILLEGAL and unused codes lock up until reset
                illegal    = 1'b1;
                state_next = S_ILLEGAL;
            end
        endcase
    end

    always_comb begin
        retire = 1'b0;
        if (state_next == S_FETCH) begin
            case (state)
                S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)      instr_count <= 32'd0;
        else if (retire) instr_count <= instr_count + 32'd1;
    end

    // Gate with RESET so an abandoned instruction drops its strobes
    // immediately, including the Mealy terms in FETCH.
    assign PCWrite    = RESET & pc_write;
    assign IRWrite    = RESET & ir_write;
    assign RegWrite   = RESET & reg_write;
    assign MemRead    = RESET & mem_read;
    assign MemWrite   = RESET & mem_write;
    assign IorD       = RESET & i_or_d;
    assign RegDst     = RESET & reg_dst;
    assign MemtoReg   = RESET & mem_to_reg;
    assign ALUSrcA    = RESET & alu_src_a;
    assign ALUSrcB    = RESET ? alu_src_b : 2'b00;
    assign ALUOp      = RESET ? alu_op : 2'b00;
    assign PCSource   = RESET ? pc_source : 2'b00;
    assign IllegalOp  = RESET & illegal;
    assign StateOut   = RESET ? state : S_FETCH;
    assign InstrCount = RESET ? instr_count : 32'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and checks every strobe against hand-derived constants.
module tb_multicycle_control;

    logic        CLK;
    logic        RESET;
    logic [5:0]  Opcode;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD;
    logic        RegDst, MemtoReg, ALUSrcA, IllegalOp;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  StateOut;
    logic [31:0] InstrCount;

    int vecs = 0;
    int errs = 0;

    multicycle_control dut (
        .CLK(CLK), .RESET(RESET), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .IllegalOp(IllegalOp), .StateOut(StateOut), .InstrCount(InstrCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {PCWrite,IRWrite,RegWrite,MemRead,MemWrite,IorD,RegDst,MemtoReg,
    //  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],IllegalOp}
    logic [15:0] outs;
    assign outs = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, RegDst, MemtoReg,
                   ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

    localparam logic [15:0] O_FETCH   = 16'hD020;
    localparam logic [15:0] O_FETCHW  = 16'h1020;
    localparam logic [15:0] O_DECODE  = 16'h0060;
    localparam logic [15:0] O_MEMADR  = 16'h00C0;
    localparam logic [15:0] O_MEMRD   = 16'h1400;
    localparam logic [15:0] O_MEMWB   = 16'h2100;
    localparam logic [15:0] O_MEMWR   = 16'h0C00;
    localparam logic [15:0] O_EXEC    = 16'h0090;
    localparam logic [15:0] O_RWB     = 16'h2200;
    localparam logic [15:0] O_BR_NT   = 16'h008A;
    localparam logic [15:0] O_BR_T    = 16'h808A;
    localparam logic [15:0] O_JUMP    = 16'h8004;
    localparam logic [15:0] O_ADDIWB  = 16'h2000;
    localparam logic [15:0] O_ILLEGAL = 16'h0001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at edge+1 with inputs already set; samples at edge+2, returns at next edge+1.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] o);
        #1;
        check({tag, " state"}, {28'd0, StateOut}, {28'd0, st});
        check({tag, " outs"}, {16'd0, outs}, {16'd0, o});
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b0; MemReady = 1'b1; Opcode = 6'd0; Zero = 1'b0;
        #3;
        check("reset outs", {16'd0, outs}, 32'd0);
        check("reset state", {28'd0, StateOut}, 32'd0);
        check("reset count", InstrCount, 32'd0);
        #5 RESET = 1'b1;  // t=8, between edges

        // R-type: 0,1,6,7,0
        cyc("rt fetch", 4'd0, O_FETCH);
        cyc("rt decode", 4'd1, O_DECODE);
        cyc("rt exec", 4'd6, O_EXEC);
        cyc("rt rwb", 4'd7, O_RWB);
        check("rt count", InstrCount, 32'd1);

        // lw with two MEMRD wait cycles; opcode scribbled during MEMRD is ignored
        Opcode = 6'd35;
        cyc("lw fetch", 4'd0, O_FETCH);
        cyc("lw decode", 4'd1, O_DECODE);
        cyc("lw memadr", 4'd2, O_MEMADR);
        MemReady = 1'b0; Opcode = 6'd63;
        cyc("lw memrd w1", 4'd3, O_MEMRD);
        cyc("lw memrd w2", 4'd3, O_MEMRD);
        MemReady = 1'b1;
        cyc("lw memrd go", 4'd3, O_MEMRD);
        cyc("lw memwb", 4'd4, O_MEMWB);
        check("lw count", InstrCount, 32'd2);

        // sw with one FETCH stall and one MEMWR wait
        Opcode = 6'd43; MemReady = 1'b0;
        cyc("sw fetch stall", 4'd0, O_FETCHW);
        MemReady = 1'b1;
        cyc("sw fetch", 4'd0, O_FETCH);
        cyc("sw decode", 4'd1, O_DECODE);
        cyc("sw memadr", 4'd2, O_MEMADR);
        MemReady = 1'b0;
        cyc("sw memwr wait", 4'd5, O_MEMWR);
        check("sw no retire while waiting", InstrCount, 32'd2);
        MemReady = 1'b1;
        cyc("sw memwr go", 4'd5, O_MEMWR);
        check("sw count", InstrCount, 32'd3);

        // beq not taken, then taken
        Opcode = 6'd4; Zero = 1'b0;
        cyc("beq0 fetch", 4'd0, O_FETCH);
        cyc("beq0 decode", 4'd1, O_DECODE);
        cyc("beq0 branch", 4'd8, O_BR_NT);
        Zero = 1'b1;
        cyc("beq1 fetch", 4'd0, O_FETCH);
        cyc("beq1 decode", 4'd1, O_DECODE);
        cyc("beq1 branch", 4'd8, O_BR_T);
        check("beq count", InstrCount, 32'd5);
        Zero = 1'b0;

        // addi with MemReady low where it must be ignored
        Opcode = 6'd8;
        cyc("addi fetch", 4'd0, O_FETCH);
        MemReady = 1'b0;
        cyc("addi decode", 4'd1, O_DECODE);
        cyc("addi ex", 4'd10, O_MEMADR);
        cyc("addi wb", 4'd11, O_ADDIWB);
        MemReady = 1'b1;
        check("addi count", InstrCount, 32'd6);

        // reset asserted mid-cycle in RWB
        Opcode = 6'd0;
        cyc("rst fetch", 4'd0, O_FETCH);
        cyc("rst decode", 4'd1, O_DECODE);
        cyc("rst exec", 4'd6, O_EXEC);
        #1;
        check("rst rwb regwrite", {31'd0, RegWrite}, 32'd1);
        #2 RESET = 1'b0;
        #1;
        check("rst regwrite drop", {31'd0, RegWrite}, 32'd0);
        check("rst state", {28'd0, StateOut}, 32'd0);
        check("rst count", InstrCount, 32'd0);
        check("rst outs", {16'd0, outs}, 32'd0);
        @(posedge CLK); #2 RESET = 1'b1;

        // j with counter preloaded at all-ones
        force dut.instr_count = 32'hFFFF_FFFF;
        #1 release dut.instr_count;
        check("wrap preload", InstrCount, 32'hFFFF_FFFF);
        Opcode = 6'd2;
        cyc("j fetch", 4'd0, O_FETCH);
        cyc("j decode", 4'd1, O_DECODE);
        cyc("j jump", 4'd9, O_JUMP);
        check("wrap count", InstrCount, 32'd0);

        // illegal opcode locks up with all strobes low
        Opcode = 6'd63;
        cyc("ill fetch", 4'd0, O_FETCH);
        cyc("ill decode", 4'd1, O_DECODE);
        for (int i = 0; i < 12; i++) begin
            MemReady = i[0];
            Zero     = i[1];
            Opcode   = (i % 3 == 0) ? 6'd0 : 6'd35;
            cyc("ill hold", 4'd15, O_ILLEGAL);
        end
        check("ill count", InstrCount, 32'd0);
        #2 RESET = 1'b0;
        #1;
        check("ill reset illegalop", {31'd0, IllegalOp}, 32'd0);
        check("ill reset state", {28'd0, StateOut}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencing controller for the MIPS datapath. It steps the shared PC, instruction memory/data memory port, register file, ALU and muxes through fetch, decode, execute, memory and write-back phases, one instruction at a time. The controller drives every datapath enable and mux select, stalls on a memory-ready handshake, and counts retired instructions. It replaces the single-cycle opcode decoder as the owner of all strobe timing.

## Interface
Parameters:
- none (opcode values fixed: R-type 0, j 2, beq 4, addi 8, lw 35, sw 43)

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- Opcode  in  6  instruction[31:26] from instruction register; valid from DECODE onward
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory port completes the current access this cycle
- PCWrite  out  1  PC load enable
- IRWrite  out  1  instruction register load enable
- RegWrite  out  1  register file write enable
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut register
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg  out  1  write data select: 0 = ALUOut, 1 = memory data register
- ALUSrcA  out  1  0 = PC, 1 = A register
- ALUSrcB  out  2  00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  out  2  00 = add, 01 = subtract, 10 = use funct field
- PCSource  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- IllegalOp  out  1  sticky, high in ILLEGAL state
- StateOut  out  4  current state code, for debug
- InstrCount  out  32  retired-instruction count

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ILLEGAL=15.
- Any output not listed for a state is 0.
- FETCH
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Hold while MemReady=0; go to DECODE when MemReady=1.
- DECODE
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by Opcode: 0 → EXEC, 35/43 → MEMADR, 4 → BRANCH, 8 → ADDIEX, 2 → JUMP, other → ILLEGAL.
- MEMADR
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next: MEMRD if Opcode=35, else MEMWR.
- MEMRD
  - Outputs: MemRead=1, IorD=1.
  - Hold until MemReady=1, then MEMWB.
- MEMWB
  - Outputs: RegDst=0, MemtoReg=1, RegWrite=1.
  - Next: FETCH.
- MEMWR
  - Outputs: MemWrite=1, IorD=1.
  - Hold until MemReady=1, then FETCH.
  - MemWrite stays high for every wait cycle; memory commits on the MemReady cycle only.
- EXEC
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next: RWB.
- RWB
  - Outputs: RegDst=1, MemtoReg=0, RegWrite=1.
  - Next: FETCH.
- BRANCH
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWrite=Zero.
  - Next: FETCH.
- JUMP
  - Outputs: PCSource=10, PCWrite=1.
  - Next: FETCH.
- ADDIEX
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next: ADDIWB.
- ADDIWB
  - Outputs: RegDst=0, MemtoReg=0, RegWrite=1.
  - Next: FETCH.
- ILLEGAL
  - Outputs: all strobes 0, IllegalOp=1.
  - Stays in ILLEGAL until RESET.
- InstrCount
  - Increments by 1 on each clock edge that moves the FSM into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or ADDIWB.
  - Wraps from 0xFFFFFFFF to 0.
  - Does not count ILLEGAL.

## Timing
- Reset
  - RESET=0 asynchronously forces state=FETCH and InstrCount=0.
  - While RESET=0, every output is forced to 0, including MemRead, PCWrite, IRWrite and StateOut (0 = FETCH).
  - Reset mid-instruction (e.g. in MEMWR or RWB) abandons the instruction and de-asserts its strobe immediately, without waiting for a clock edge.
  - First FETCH outputs appear in the cycle RESET is sampled high.
- Output timing
  - All outputs are combinational from the registered state.
  - PCWrite in FETCH/BRANCH and IRWrite are Mealy on MemReady/Zero, with no added register stage.
  - The datapath samples strobes on the next rising CLK edge.
- Cycles per instruction with MemReady constantly 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemReady is ignored in every state other than FETCH, MEMRD and MEMWR.
- Opcode is sampled only in DECODE and MEMADR; changes in other states have no effect.

## Test plan
- Reset then run with MemReady=1, Opcode=0: StateOut sequence 0,1,6,7,0; RegWrite=1 with RegDst=1 in cycle 4 only; InstrCount=1.
- lw (35) with MemReady=0 for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0; MemRead=IorD=1 for all three MEMRD cycles; 7 cycles total; MemtoReg=1 in MEMWB.
- sw (43), then beq (4) with Zero=0, then beq with Zero=1: MemWrite=1 only in MEMWR; PCWrite=0 in the first BRANCH and 1 in the second with PCSource=01; InstrCount=3.
- Opcode=63: DECODE→ILLEGAL; IllegalOp=1 and all strobes 0 for 10+ cycles; InstrCount unchanged; RESET low clears IllegalOp asynchronously.
- Assert RESET=0 mid-cycle in RWB: RegWrite drops before the next edge; StateOut=0; InstrCount=0.
- Preload InstrCount at 0xFFFFFFFF (force), complete one j (2): InstrCount=0; PCWrite=1 with PCSource=10 in JUMP.
